// File: rtl/evm_ballot_unit.sv
// evm_ballot_unit
//   Voter-facing front end of the voting machine. It conditions the presiding
//   officer's arm button and the four candidate buttons, allows exactly one
//   vote per armed ballot, and hands each accepted vote to the tally block.
//
//   Optional feature macro: EVM_BALLOT_TIMEOUT_EN
//     When defined, an armed ballot that sees no accepted press within
//     TIMEOUT_CYCLES cycles is cancelled with a one-cycle timeout pulse.
//     When undefined, ARMED waits indefinitely and timeout is constant 0.
//
//   Ports:
//     clk         in   1  system clock, rising edge
//     reset       in   1  synchronous, active-high reset
//     arm         in   1  raw arm button (asynchronous)
//     btn         in   4  raw candidate buttons (asynchronous), bit n = candidate n
//     vote_valid  out  1  accepted vote presented to the tally
//     vote_cand   out  2  candidate index, meaningful while vote_valid=1
//     vote_ready  in   1  tally accepts the vote this cycle
//     ready_led   out  1  high while the ballot is armed
//     ballot_cnt  out 16  votes transferred, saturating at 16'hFFFF
//     multi_err   out  1  one-cycle pulse: two or more buttons pressed together
//     timeout     out  1  one-cycle pulse: armed ballot expired
//     dbg_state   out  2  current FSM state (IDLE=0, ARMED=1, SEND=2, RELEASE=3)
//
//   Handshake: vote_valid/vote_cand are held stable from the cycle vote_valid
//   rises until a rising clock edge samples vote_ready=1; that edge completes
//   the transfer, and vote_valid drops while ballot_cnt shows the new total on
//   the following cycle. vote_valid never depends combinationally on vote_ready.

module evm_ballot_unit #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        arm,
  input  logic [3:0]  btn,
  output logic        vote_valid,
  output logic [1:0]  vote_cand,
  input  logic        vote_ready,
  output logic        ready_led,
  output logic [15:0] ballot_cnt,
  output logic        multi_err,
  output logic        timeout,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_SEND    = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  // Debounce counter only needs to reach DEBOUNCE_CYCLES-1.
  localparam int              DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("evm_ballot_unit: DEBOUNCE_CYCLES and TIMEOUT_CYCLES must be >= 1");
  end

  // ---------------------------------------------------------------------------
  // Input conditioning: bit 4 is arm, bits 3:0 are the candidate buttons.
  // ---------------------------------------------------------------------------
  logic [4:0]      w_raw;
  logic [4:0]      r_sync1;
  logic [4:0]      r_sync2;
  logic [4:0]      r_deb;
  logic [DB_W-1:0] r_db_cnt [5];

  assign w_raw = {arm, btn};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      for (int i = 0; i < 5; i++) r_db_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      for (int i = 0; i < 5; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          // This is the DEBOUNCE_CYCLES-th consecutive differing cycle.
          r_deb[i]    <= r_sync2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  logic       r_arm_prev;
  logic       w_arm_pulse;
  logic [3:0] w_btn;
  logic       w_multi;
  logic       w_onehot;
  logic [1:0] w_enc;

  always_ff @(posedge clk) begin
    if (reset) r_arm_prev <= 1'b0;
    else       r_arm_prev <= r_deb[4];
  end

  assign w_arm_pulse = r_deb[4] & ~r_arm_prev;
  assign w_btn       = r_deb[3:0];
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign w_multi     = (w_btn & (w_btn - 4'd1)) != 4'd0;
  assign w_onehot    = (w_btn != 4'd0) && !w_multi;

  always_comb begin
    w_enc = 2'd0;
    case (w_btn)
      4'b0010: w_enc = 2'd1;
      4'b0100: w_enc = 2'd2;
      4'b1000: w_enc = 2'd3;
      default: w_enc = 2'd0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Ballot FSM
  // ---------------------------------------------------------------------------
  logic [1:0]  r_state;
  logic [1:0]  r_cand;
  logic [15:0] r_cnt;
  logic        r_clean;
  logic        r_multi_err;
  logic        r_timeout;
  logic        w_expire;

`ifdef EVM_BALLOT_TIMEOUT_EN
  localparam int              TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] r_to_cnt;

  // r_to_cnt holds the number of ARMED cycles already elapsed, so the
  // TIMEOUT_CYCLES-th ARMED cycle is the one that sees TO_LAST.
  always_ff @(posedge clk) begin
    if (reset)                                r_to_cnt <= '0;
    else if (r_state == S_IDLE && w_arm_pulse) r_to_cnt <= '0;
    else if (r_state == S_ARMED)              r_to_cnt <= r_to_cnt + TO_W'(1);
  end

  assign w_expire = (r_to_cnt == TO_LAST);
`else
  assign w_expire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cand      <= 2'd0;
      r_cnt       <= 16'd0;
      r_clean     <= 1'b0;
      r_multi_err <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_multi_err <= 1'b0;
      r_timeout   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_arm_pulse) begin
            r_state <= S_ARMED;
            // A button already held at arming must be released before it counts.
            r_clean <= (w_btn == 4'd0);
          end
        end
        S_ARMED: begin
          // A valid press on the expiry cycle takes precedence over the timeout.
          if (r_clean && w_onehot) begin
            r_state <= S_SEND;
            r_cand  <= w_enc;
          end else if (w_expire) begin
            r_state   <= S_IDLE;
            r_timeout <= 1'b1;
          end else if (!r_clean) begin
            if (w_btn == 4'd0) r_clean <= 1'b1;
          end else if (w_multi) begin
            r_multi_err <= 1'b1;
            r_clean     <= 1'b0;
          end
        end
        S_SEND: begin
          if (vote_ready) begin
            if (r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
            r_state <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (w_btn == 4'd0) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign vote_valid = (r_state == S_SEND);
  assign vote_cand  = vote_valid ? r_cand : 2'd0;
  assign ready_led  = (r_state == S_ARMED);
  assign ballot_cnt = r_cnt;
  assign multi_err  = r_multi_err;
  assign timeout    = r_timeout;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_evm_ballot_unit.sv
// Testbench for evm_ballot_unit: table-driven ballots, hand-written corner
// sequences, and randomized stimulus checked every cycle against a
// behavioural reference model.
module tb_evm_ballot_unit;

  localparam int DB = 4;
  localparam int TO = 50;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic        arm;
  logic [3:0]  btn;
  logic        vote_ready;
  logic        vote_valid;
  logic [1:0]  vote_cand;
  logic        ready_led;
  logic [15:0] ballot_cnt;
  logic        multi_err;
  logic        timeout;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  evm_ballot_unit #(.DEBOUNCE_CYCLES(DB), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .arm(arm), .btn(btn),
    .vote_valid(vote_valid), .vote_cand(vote_cand), .vote_ready(vote_ready),
    .ready_led(ready_led), .ballot_cnt(ballot_cnt), .multi_err(multi_err),
    .timeout(timeout), .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  typedef enum {PH_IDLE, PH_ARMED, PH_VOTE, PH_DRAIN} phase_t;

  logic [4:0] m_pipe [2];   // raw inputs as seen one and two edges ago
  logic [4:0] m_hist [DB];  // last DB synchronised samples, newest first
  logic [4:0] m_deb;
  logic [4:0] m_deb_prev;
  phase_t     m_ph;
  bit         m_clean;
  int         m_armed_n;
  int         m_cand;
  int         m_count;
  bit         m_multi;
  bit         m_timeout;

  task automatic model_reset();
    m_pipe[0] = '0; m_pipe[1] = '0;
    for (int k = 0; k < DB; k++) m_hist[k] = '0;
    m_deb = '0; m_deb_prev = '0;
    m_ph = PH_IDLE; m_clean = 0; m_armed_n = 0; m_cand = 0;
    m_count = 0; m_multi = 0; m_timeout = 0;
  endtask

  task automatic model_edge();
    logic [3:0] b;
    int         ones;
    bit         pulse;
    bit         all_diff;
    if (reset) begin
      model_reset();
      return;
    end
    b     = m_deb[3:0];
    ones  = $countones(b);
    pulse = m_deb[4] && !m_deb_prev[4];
    m_multi   = 0;
    m_timeout = 0;
    case (m_ph)
      PH_IDLE: if (pulse) begin
        m_ph = PH_ARMED; m_clean = (ones == 0); m_armed_n = 0;
      end
      PH_ARMED: begin
        m_armed_n++;
        if (m_clean && ones == 1) begin
          m_ph = PH_VOTE;
          for (int i = 0; i < 4; i++) if (b[i]) m_cand = i;
        end
`ifdef EVM_BALLOT_TIMEOUT_EN
        else if (m_armed_n == TO) begin
          m_ph = PH_IDLE; m_timeout = 1;
        end
`endif
        else if (!m_clean) begin
          if (ones == 0) m_clean = 1;
        end else if (ones >= 2) begin
          m_multi = 1; m_clean = 0;
        end
      end
      PH_VOTE: if (vote_ready) begin
        if (m_count < 65535) m_count++;
        m_ph = PH_DRAIN;
      end
      PH_DRAIN: if (ones == 0) m_ph = PH_IDLE;
      default: m_ph = PH_IDLE;
    endcase
    // A debounced input follows once the last DB synchronised samples all disagree with it.
    m_deb_prev = m_deb;
    for (int k = DB - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = m_pipe[1];
    for (int j = 0; j < 5; j++) begin
      all_diff = 1;
      for (int k = 0; k < DB; k++) if (m_hist[k][j] == m_deb[j]) all_diff = 0;
      if (all_diff) m_deb[j] = ~m_deb[j];
    end
    m_pipe[1] = m_pipe[0];
    m_pipe[0] = {arm, btn};
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic       e_vv;
    logic [1:0] e_cand;
    logic       e_rdy;
    logic       e_to;
    e_vv   = (m_ph == PH_VOTE);
    e_cand = e_vv ? 2'(m_cand) : 2'd0;
    e_rdy  = (m_ph == PH_ARMED);
    e_to   = m_timeout;
    n_checks++;
    if ({vote_valid, vote_cand, ready_led, ballot_cnt, multi_err, timeout} !==
        {e_vv, e_cand, e_rdy, 16'(m_count), m_multi, e_to}) begin
      n_fail++;
      $display("FAIL model t=%0t got vv=%b cand=%0d rdy=%b cnt=%0d me=%b to=%b expected vv=%b cand=%0d rdy=%b cnt=%0d me=%b to=%b",
               $time, vote_valid, vote_cand, ready_led, ballot_cnt, multi_err, timeout,
               e_vv, e_cand, e_rdy, m_count, m_multi, e_to);
    end
  endtask

  // One clock: the model advances on the rising edge, outputs are compared on the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model();
  endtask

  // ---------------- driver tasks ----------------
  task automatic press_arm();
    arm = 1'b1;
    repeat (8) step();
    arm = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    for (int i = 0; i < 20 && !ready_led; i++) step();
    check(name, ready_led, 1);
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 20 && !vote_valid; i++) step();
    check(name, vote_valid, 1);
  endtask

  // Press a pattern for 'hold' cycles and watch 15 cycles past release.
  task automatic press_pattern(input logic [3:0] pat, input int hold,
                               output int vv_n, output int multi_n,
                               output int lat, output int cand_seen);
    vv_n = 0; multi_n = 0; lat = -1; cand_seen = -1;
    btn = pat;
    for (int s = 1; s <= hold + 15; s++) begin
      if (s == hold + 1) btn = 4'd0;
      step();
      if (vote_valid) begin
        vv_n++;
        if (lat < 0) lat = s;
        cand_seen = int'(vote_cand);
      end
      if (multi_err) multi_n++;
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0] pat;
    int         hold;
    logic       exp_vote;
    logic [1:0] exp_cand;
    int         exp_multi;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs [NV];

  int exp_cnt;
  int vv_n, multi_n, lat, cand_seen, hi, rdy_n, n, i0, to_n, r, p;

  initial begin
    vecs[0] = '{4'b0100, 12, 1'b1, 2'd2, 0};
    vecs[1] = '{4'b0010,  2, 1'b0, 2'd0, 0};   // short glitch
    vecs[2] = '{4'b1000, 12, 1'b1, 2'd3, 0};
    vecs[3] = '{4'b1001, 12, 1'b0, 2'd0, 1};
    vecs[4] = '{4'b0010, 12, 1'b1, 2'd1, 0};
    vecs[5] = '{4'b0110, 12, 1'b0, 2'd0, 1};
    vecs[6] = '{4'b0001, 12, 1'b1, 2'd0, 0};
    vecs[7] = '{4'b1111, 12, 1'b0, 2'd0, 1};
    vecs[8] = '{4'b0100, 12, 1'b1, 2'd2, 0};

    reset = 1'b1; arm = 1'b0; btn = 4'd0; vote_ready = 1'b0;
    exp_cnt = 0;
    step(); step();
    check("rst_vote_valid", vote_valid, 0);
    check("rst_vote_cand",  vote_cand, 0);
    check("rst_ready_led",  ready_led, 0);
    check("rst_ballot_cnt", ballot_cnt, 0);
    check("rst_multi_err",  multi_err, 0);
    check("rst_timeout",    timeout, 0);
    reset = 1'b0;
    repeat (3) step();

    // -------- table-driven ballots (vote_ready held high) --------
    for (int t = 0; t < NV; t++) begin
      if (!ready_led) begin
        press_arm();
        wait_ready($sformatf("tbl%0d_arm", t));
      end
      vote_ready = 1'b1;
      press_pattern(vecs[t].pat, vecs[t].hold, vv_n, multi_n, lat, cand_seen);
      check($sformatf("tbl%0d_valid_cycles", t), vv_n, vecs[t].exp_vote ? 1 : 0);
      check($sformatf("tbl%0d_multi", t), multi_n, vecs[t].exp_multi);
      if (vecs[t].exp_vote) begin
        exp_cnt++;
        check($sformatf("tbl%0d_cand", t), cand_seen, vecs[t].exp_cand);
        check($sformatf("tbl%0d_latency", t), lat, DB + 3);
        check($sformatf("tbl%0d_idle_led", t), ready_led, 0);
      end else begin
        check($sformatf("tbl%0d_still_armed", t), ready_led, 1);
      end
      check($sformatf("tbl%0d_cnt", t), ballot_cnt, exp_cnt);
    end

    // -------- back-pressure: ready low 5 cycles --------
    press_arm();
    wait_ready("bp_arm");
    vote_ready = 1'b0;
    btn = 4'b1000;
    wait_valid("bp_valid_rise");
    hi = 1;
    check("bp_cand_first", vote_cand, 3);
    repeat (5) begin
      step();
      if (vote_valid) hi++;
      check("bp_cand_hold", vote_cand, 3);
    end
    vote_ready = 1'b1;
    step();
    exp_cnt++;
    check("bp_valid_cycles", hi, 6);
    check("bp_valid_drop", vote_valid, 0);
    check("bp_cnt", ballot_cnt, exp_cnt);

    // Second arm while btn[3] still held: discarded.
    vv_n = 0; rdy_n = 0;
    arm = 1'b1;
    for (int s = 0; s < 28; s++) begin
      if (s == 8) arm = 1'b0;
      step();
      if (vote_valid) vv_n++;
      if (ready_led) rdy_n++;
    end
    check("held_no_vote", vv_n, 0);
    check("held_no_arm", rdy_n, 0);
    btn = 4'd0;
    repeat (15) step();
    check("held_release_idle", ready_led, 0);
    press_arm();
    wait_ready("repress_arm");
    press_pattern(4'b1000, 12, vv_n, multi_n, lat, cand_seen);
    exp_cnt++;
    check("repress_vote", vv_n, 1);
    check("repress_cand", cand_seen, 3);
    check("repress_cnt", ballot_cnt, exp_cnt);

    // -------- timeout behaviour --------
    arm = 1'b1; i0 = -1; n = 0; to_n = 0;
`ifdef EVM_BALLOT_TIMEOUT_EN
    while (n < 200 && !timeout) begin
      if (n == 8) arm = 1'b0;
      step();
      n++;
      if (ready_led && i0 < 0) i0 = n;
    end
    arm = 1'b0;
    check("to_armed_seen", (i0 > 0) ? 1 : 0, 1);
    check("to_delay", n - i0, TO);
    check("to_pulse", timeout, 1);
    check("to_led_drop", ready_led, 0);
    step();
    check("to_pulse_width", timeout, 0);
    vote_ready = 1'b1;
    press_pattern(4'b0001, 12, vv_n, multi_n, lat, cand_seen);
    check("to_late_press", vv_n, 0);
    check("to_late_cnt", ballot_cnt, exp_cnt);
`else
    while (n < 80) begin
      if (n == 8) arm = 1'b0;
      step();
      n++;
      if (timeout) to_n++;
    end
    arm = 1'b0;
    check("noto_pulses", to_n, 0);
    check("noto_still_armed", ready_led, 1);
    vote_ready = 1'b1;
    press_pattern(4'b0100, 12, vv_n, multi_n, lat, cand_seen);
    exp_cnt++;
    check("noto_late_vote", vv_n, 1);
    check("noto_cnt", ballot_cnt, exp_cnt);
`endif

    // -------- reset while a vote is pending --------
    press_arm();
    wait_ready("rs_arm");
    vote_ready = 1'b0;
    btn = 4'b0001;
    wait_valid("rs_valid");
    reset = 1'b1;
    step();
    check("rs_valid_drop", vote_valid, 0);
    check("rs_cnt_clear", ballot_cnt, 0);
    check("rs_led", ready_led, 0);
    reset = 1'b0;
    btn = 4'd0;
    exp_cnt = 0;
    repeat (12) step();
    check("rs_no_resend", vote_valid, 0);
    check("rs_cnt_hold", ballot_cnt, exp_cnt);

    // -------- randomized stimulus against the model --------
    repeat (4000) begin
      r = $urandom_range(0, 99);
      if (r < 6) arm = ~arm;
      else if (r < 14) begin
        p = $urandom_range(0, 9);
        if (p < 4)      btn = 4'(1 << p);
        else if (p < 7) btn = 4'd0;
        else            btn = 4'($urandom);
      end
      vote_ready = ($urandom_range(0, 2) != 0);
      reset = ($urandom_range(0, 999) == 0);
      step();
    end
    reset = 1'b0; arm = 1'b0; btn = 4'd0; vote_ready = 1'b1;
    repeat (20) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
